// File: rtl/sequenciador_rodadas_pkg.sv
// Shared types and helpers for the round sequencer: FSM states, grade limits,
// LFSR step and the mod-10 mapping from LFSR value to target value.
package sequenciador_pkg;

  typedef enum logic [2:0] {
    OCIOSO,
    APRESENTA,
    AMOSTRA,
    AVALIA,
    PROXIMA,
    FIM
  } estado_t;

  localparam logic [3:0] NOTA_MIN      = 4'd1;
  localparam logic [3:0] NOTA_INVALIDA = 4'd11;
  localparam logic [3:0] NOTA_MAX      = NOTA_INVALIDA - 4'd1;

  function automatic logic [3:0] lfsr_proximo(input logic [3:0] valor);
    return {valor[2:0], valor[3] ^ valor[2]};
  endfunction

  // The LFSR never reaches 0, so values 10..15 fold onto 0..5.
  function automatic logic [3:0] mapeia_ideal(input logic [3:0] valor);
    return (valor < 4'd10) ? valor : valor - 4'd10;
  endfunction

  function automatic logic nota_aceita(input logic [3:0] valor);
    return (valor >= NOTA_MIN) && (valor <= NOTA_MAX);
  endfunction

endpackage

// File: rtl/sequenciador_rodadas_gerador_ideal.sv
// Pseudo-random target generator: 4-bit LFSR plus mod-10 mapping.
// The ideal output is a look-ahead: the mapped value the LFSR holds after this edge.
module gerador_ideal
  import sequenciador_pkg::*;
#(
  parameter logic [3:0] SEMENTE = 4'b0001
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       carregar,
  input  logic       avancar,
  output logic [3:0] ideal
);

  logic [3:0] lfsr;
  logic [3:0] lfsr_seguinte;

  always_comb begin
    lfsr_seguinte = lfsr;
    if (carregar)
      lfsr_seguinte = SEMENTE;
    else if (avancar)
      lfsr_seguinte = lfsr_proximo(lfsr);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      lfsr <= SEMENTE;
    else
      lfsr <= lfsr_seguinte;
  end

  assign ideal = mapeia_ideal(lfsr_seguinte);

endmodule

// File: rtl/sequenciador_rodadas.sv
// Round sequencer: presents a target per round, waits a settling window,
// freezes the sensor, strobes the grader and accumulates the returned grades.
module sequenciador_rodadas
  import sequenciador_pkg::*;
#(
  parameter int          N_RODADAS    = 8,
  parameter int          TEMPO_ESPERA = 50,
  parameter logic [3:0]  SEMENTE      = 4'b0001
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic [3:0] sensor,
  input  logic [3:0] nota,
  output logic [3:0] ideal,
  output logic [3:0] sensor_amostra,
  output logic       enable,
  output logic [3:0] rodada,
  output logic [7:0] pontuacao,
  output logic       nota_valida,
  output logic       erro,
  output logic       fim
);

  localparam int            CW      = $clog2(TEMPO_ESPERA + 1);
  localparam logic [CW-1:0] RECARGA = CW'(TEMPO_ESPERA - 1);
  localparam logic [3:0]    ULTIMA  = 4'(N_RODADAS - 1);

  estado_t       estado;
  logic [CW-1:0] contador;
  logic [3:0]    ideal_prox;
  logic          partida;
  logic          avancar;

  assign partida = iniciar && ((estado == OCIOSO) || (estado == FIM));
  assign avancar = (estado == PROXIMA);

  gerador_ideal #(.SEMENTE(SEMENTE)) u_gerador (
    .clock    (clock),
    .reset_n  (reset_n),
    .carregar (partida),
    .avancar  (avancar),
    .ideal    (ideal_prox)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado         <= OCIOSO;
      contador       <= '0;
      ideal          <= '0;
      sensor_amostra <= '0;
      enable         <= 1'b0;
      rodada         <= '0;
      pontuacao      <= '0;
      nota_valida    <= 1'b0;
      erro           <= 1'b0;
      fim            <= 1'b0;
    end else begin
      enable      <= 1'b0;
      nota_valida <= 1'b0;
      case (estado)
        OCIOSO, FIM: begin
          if (iniciar) begin
            rodada    <= '0;
            pontuacao <= '0;
            erro      <= 1'b0;
            fim       <= 1'b0;
            ideal     <= ideal_prox;
            contador  <= RECARGA;
            estado    <= APRESENTA;
          end
        end
        // enable is registered, so it is raised on the edge that enters AMOSTRA.
        APRESENTA: begin
          if (contador == '0) begin
            enable <= 1'b1;
            estado <= AMOSTRA;
          end else begin
            contador <= contador - 1'b1;
          end
        end
        AMOSTRA: begin
          sensor_amostra <= sensor;
          estado         <= AVALIA;
        end
        AVALIA: begin
          nota_valida <= 1'b1;
          if (nota_aceita(nota))
            pontuacao <= pontuacao + {4'd0, nota};
          else
            erro <= 1'b1;
          estado <= PROXIMA;
        end
        PROXIMA: begin
          if (rodada == ULTIMA) begin
            fim    <= 1'b1;
            estado <= FIM;
          end else begin
            rodada   <= rodada + 1'b1;
            ideal    <= ideal_prox;
            contador <= RECARGA;
            estado   <= APRESENTA;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_sequenciador_rodadas.sv
// Directed self-checking bench for sequenciador_rodadas with a small grader model.
module tb_sequenciador_rodadas;
  import sequenciador_pkg::*;

  localparam int T = 5;

  logic       clock;
  logic       reset_n;
  logic       iniciar;
  logic [3:0] sensor;
  logic [3:0] nota;
  logic [3:0] ideal;
  logic [3:0] sensor_amostra;
  logic       enable;
  logic [3:0] rodada;
  logic [7:0] pontuacao;
  logic       nota_valida;
  logic       erro;
  logic       fim;

  int checks;
  int errors;
  int cycles;
  int enHigh;
  int mode;

  logic [3:0] seqIdeal [8];

  sequenciador_rodadas #(.N_RODADAS(8), .TEMPO_ESPERA(T), .SEMENTE(4'b0001)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .iniciar        (iniciar),
    .sensor         (sensor),
    .nota           (nota),
    .ideal          (ideal),
    .sensor_amostra (sensor_amostra),
    .enable         (enable),
    .rodada         (rodada),
    .pontuacao      (pontuacao),
    .nota_valida    (nota_valida),
    .erro           (erro),
    .fim            (fim)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Grader model: mode 0 rewards an exact match, mode 1 returns 11 in round index 1 and 7 otherwise.
  assign nota = (mode == 0) ? ((sensor_amostra == ideal) ? 4'd10 : 4'd1)
                            : ((rodada == 4'd1) ? 4'd11 : 4'd7);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    if (enable) enHigh++;
    @(negedge clock);
    cycles++;
  endtask

  task automatic applyStimulus();
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".ideal"}, ideal, 0);
    checkOutput({tag, ".amostra"}, sensor_amostra, 0);
    checkOutput({tag, ".enable"}, enable, 0);
    checkOutput({tag, ".rodada"}, rodada, 0);
    checkOutput({tag, ".pontuacao"}, pontuacao, 0);
    checkOutput({tag, ".nota_valida"}, nota_valida, 0);
    checkOutput({tag, ".erro"}, erro, 0);
    checkOutput({tag, ".fim"}, fim, 0);
  endtask

  // Called at the first falling edge of APRESENTA; leaves the bench at the first falling edge of the next state.
  task automatic runRound(input int r, input int expScore, input logic expErro, input bit pulseStart);
    checkOutput($sformatf("ideal r%0d", r), ideal, seqIdeal[r]);
    checkOutput($sformatf("rodada r%0d", r), rodada, r);
    for (int k = 0; k < T; k++) begin
      sensor  = 4'((int'(seqIdeal[r]) + 1 + k) % 10);
      iniciar = pulseStart && (k == 1);
      checkOutput($sformatf("enable idle r%0d", r), enable, 0);
      step();
    end
    iniciar = 1'b0;
    checkOutput($sformatf("enable r%0d", r), enable, 1);
    checkOutput($sformatf("rodada hold r%0d", r), rodada, r);
    sensor = seqIdeal[r];
    step();
    sensor = 4'((int'(seqIdeal[r]) + 3) % 10);
    checkOutput($sformatf("amostra r%0d", r), sensor_amostra, seqIdeal[r]);
    checkOutput($sformatf("enable off r%0d", r), enable, 0);
    step();
    checkOutput($sformatf("nota_valida r%0d", r), nota_valida, 1);
    checkOutput($sformatf("pontuacao r%0d", r), pontuacao, expScore);
    checkOutput($sformatf("erro r%0d", r), erro, expErro);
    step();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cycles  = 0;
    enHigh  = 0;
    mode    = 0;
    reset_n = 1'b0;
    iniciar = 1'b0;
    sensor  = 4'd0;
    seqIdeal = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd3, 4'd0};

    #12;
    checkIdle("reset");
    @(negedge clock);
    reset_n = 1'b1;
    step();
    step();
    checkIdle("idle");

    $display("[TB] game 1: perfect play");
    cycles = 0;
    enHigh = 0;
    applyStimulus();
    for (int r = 0; r < 8; r++) runRound(r, 10 * (r + 1), 1'b0, 1'b0);
    checkOutput("fim g1", fim, 1);
    checkOutput("pontuacao g1", pontuacao, 80);
    checkOutput("erro g1", erro, 0);
    checkOutput("rodada g1", rodada, 7);
    checkOutput("ideal g1", ideal, 0);
    checkOutput("cycles g1", cycles, 8 * (T + 3) + 1);
    checkOutput("enable count g1", enHigh, 8);

    $display("[TB] game 2: invalid grade and ignored starts");
    mode = 1;
    applyStimulus();
    checkOutput("fim restart", fim, 0);
    checkOutput("pontuacao restart", pontuacao, 0);
    checkOutput("rodada restart", rodada, 0);
    checkOutput("ideal restart", ideal, 1);
    checkOutput("erro restart", erro, 0);
    for (int r = 0; r < 8; r++)
      runRound(r, 7 * (r + 1) - ((r >= 1) ? 7 : 0), (r >= 1), (r == 0) || (r == 3));
    checkOutput("fim g2", fim, 1);
    checkOutput("pontuacao g2", pontuacao, 49);
    checkOutput("erro g2", erro, 1);
    step();
    step();
    checkOutput("erro sticky", erro, 1);
    checkOutput("fim hold", fim, 1);
    checkOutput("pontuacao hold", pontuacao, 49);

    $display("[TB] game 3: reset mid-round");
    mode = 0;
    applyStimulus();
    runRound(0, 10, 1'b0, 1'b0);
    step();
    step();
    reset_n = 1'b0;
    #1;
    checkIdle("midreset");
    checkOutput("estado midreset", 32'(dut.estado), 32'(OCIOSO));
    checkOutput("lfsr midreset", dut.u_gerador.lfsr, 1);
    step();
    reset_n = 1'b1;
    step();
    step();
    step();
    checkIdle("postreset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
